prefix_adder_arbiter: RTL and testbench

Shares one `prefix_adder_16bit` instance between two requesters, with round-robin arbitration and valid/ready handshakes on both sides. Per-requester carry chaining lets each requester issue multi-word (32/48/64-bit…) additions as back-to-back 16-bit words. While a multi-word transaction is in progress, the arbiter locks the adder to that requester. The result is a single registered output stage, so the block sits between the two datapath clients and the combinational adder.

---
 rtl/prefix_adder_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_prefix_adder_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_adder_arbiter.sv
// ---------------------------------------------------------------------------
// prefix_adder_arbiter
//
// Two requesters share one 16-bit parallel-prefix adder. Requests use
// valid/ready handshakes. Arbitration is round-robin. Each requester has its
// own carry register, so it can chain back-to-back 16-bit words into wider
// additions. While a multi-word transaction is open, the adder stays locked
// to its owner. A lock whose owner goes quiet for LOCK_TIMEOUT cycles is
// aborted. Results leave through a single registered output stage.
//
// Parameters
//   LOCK_TIMEOUT  idle cycles tolerated inside a locked transaction
//                 (0 = never abort)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   rN_valid / rN_ready          request handshake, N = 0,1
//   rN_a, rN_b                   16-bit operands
//   rN_cin                       carry-in, only used on first=1 words
//   rN_first / rN_last           transaction framing (single word: both 1)
//   rsp_valid / rsp_ready        response handshake
//   rsp_sum, rsp_cout            result word and its carry-out
//   rsp_id, rsp_last             issuing requester, copy of the last flag
//   rsp_ovf                      signed overflow of the word
//                                (only when PPA_ARB_OVF_EN is defined)
//   lock_abort                   one-cycle pulse when a lock times out
//
// Optional feature macro: PPA_ARB_OVF_EN
// ---------------------------------------------------------------------------

// Kogge-Stone adder. The carry-in is folded in after the prefix tree:
// c[i+1] = G[i:0] | P[i:0] & cin
module prefix_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p0;
  logic [15:0] g_cur;
  logic [15:0] p_cur;
  logic [15:0] g_nxt;
  logic [15:0] p_nxt;
  logic [16:0] carry;

  always_comb begin
    p0    = a ^ b;
    g_cur = a & b;
    p_cur = p0;
    g_nxt = '0;
    p_nxt = '0;
    for (int l = 0; l < 4; l++) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int i = (1 << l); i < 16; i++) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
        p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    carry[0] = cin;
    for (int i = 0; i < 16; i++) begin
      carry[i + 1] = g_cur[i] | (p_cur[i] & cin);
    end
    sum  = p0 ^ carry[15:0];
    cout = carry[16];
  end
endmodule

module prefix_adder_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_a,
  input  logic [15:0] r0_b,
  input  logic        r0_cin,
  input  logic        r0_first,
  input  logic        r0_last,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_a,
  input  logic [15:0] r1_b,
  input  logic        r1_cin,
  input  logic        r1_first,
  input  logic        r1_last,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_id,
  output logic        rsp_last,
`ifdef PPA_ARB_OVF_EN
  output logic        rsp_ovf,
`endif
  output logic        lock_abort
);
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(LOCK_TIMEOUT);

  // Requester inputs gathered into vectors indexed by requester id.
  logic [1:0]  req_valid;
  logic [1:0]  req_cin;
  logic [1:0]  req_first;
  logic [1:0]  req_last;
  logic [15:0] req_a [2];
  logic [15:0] req_b [2];

  assign req_valid = {r1_valid, r0_valid};
  assign req_cin   = {r1_cin,   r0_cin};
  assign req_first = {r1_first, r0_first};
  assign req_last  = {r1_last,  r0_last};
  assign req_a[0]  = r0_a;
  assign req_a[1]  = r1_a;
  assign req_b[0]  = r0_b;
  assign req_b[1]  = r1_b;

  // Shared state
  logic          rr_ptr_reg;
  logic          lock_v_reg;
  logic          lock_id_reg;
  logic [CW-1:0] idle_cnt_reg;
  logic          out_v_reg;
  logic [15:0]   out_sum_reg;
  logic          out_cout_reg;
  logic          out_id_reg;
  logic          out_last_reg;
  logic          lock_abort_reg;
  logic [1:0]    carry_reg;

  // Arbitration and datapath
  logic        can_accept;
  logic [1:0]  gnt;
  logic [1:0]  ready;
  logic        accept;
  logic        sel;
  logic        sel_last;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        lock_valid;
  logic        timeout_hit;

  assign can_accept = !out_v_reg || rsp_ready;

  always_comb begin
    gnt = 2'b00;
    if (lock_v_reg) begin
      gnt[lock_id_reg] = req_valid[lock_id_reg];
    end else if (req_valid == 2'b11) begin
      gnt[rr_ptr_reg] = 1'b1;
    end else begin
      gnt = req_valid;
    end
  end

  // gnt is one-hot or zero, so sel simply names the accepted requester.
  assign ready    = gnt & {2{can_accept}};
  assign accept   = |ready;
  assign sel      = ready[1];
  assign sel_last = req_last[sel];
  assign add_cin  = req_first[sel] ? req_cin[sel] : carry_reg[sel];
  assign r0_ready = ready[0];
  assign r1_ready = ready[1];

  prefix_adder_16bit u_adder (
    .a    (req_a[sel]),
    .b    (req_b[sel]),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A locked owner that keeps valid high (even while stalled by backpressure)
  // is never considered idle, so valid always beats the timeout.
  assign lock_valid  = req_valid[lock_id_reg];
  assign timeout_hit = (LOCK_TIMEOUT != 0) && lock_v_reg && !lock_valid &&
                       (idle_cnt_reg == TO_VAL);

  // Per-requester carry chain
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_carry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          carry_reg[gi] <= 1'b0;
        end else if (accept && (sel == 1'(gi))) begin
          carry_reg[gi] <= sel_last ? 1'b0 : add_cout;
        end else if (timeout_hit && (lock_id_reg == 1'(gi))) begin
          carry_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (!lock_v_reg || lock_valid || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else if (idle_cnt_reg != TO_VAL) begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg     <= 1'b0;
      lock_v_reg     <= 1'b0;
      lock_id_reg    <= 1'b0;
      out_v_reg      <= 1'b0;
      out_sum_reg    <= '0;
      out_cout_reg   <= 1'b0;
      out_id_reg     <= 1'b0;
      out_last_reg   <= 1'b0;
      lock_abort_reg <= 1'b0;
    end else begin
      lock_abort_reg <= timeout_hit;
      if (accept) begin
        out_v_reg    <= 1'b1;
        out_sum_reg  <= add_sum;
        out_cout_reg <= add_cout;
        out_id_reg   <= sel;
        out_last_reg <= sel_last;
        if (sel_last) begin
          lock_v_reg <= 1'b0;
          rr_ptr_reg <= ~sel;
        end else begin
          lock_v_reg  <= 1'b1;
          lock_id_reg <= sel;
        end
      end else begin
        if (rsp_ready) begin
          out_v_reg <= 1'b0;
        end
        // Abort cannot coincide with an accept: only the owner may be
        // accepted while locked, and abort requires the owner to be idle.
        if (timeout_hit) begin
          lock_v_reg <= 1'b0;
          rr_ptr_reg <= ~lock_id_reg;
        end
      end
    end
  end

`ifdef PPA_ARB_OVF_EN
  logic out_ovf_reg;
  logic add_ovf;

  assign add_ovf = (req_a[sel][15] == req_b[sel][15]) &&
                   (add_sum[15] != req_a[sel][15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf_reg <= 1'b0;
    end else if (accept) begin
      out_ovf_reg <= add_ovf;
    end
  end

  assign rsp_ovf = out_ovf_reg;
`endif

  assign rsp_valid  = out_v_reg;
  assign rsp_sum    = out_sum_reg;
  assign rsp_cout   = out_cout_reg;
  assign rsp_id     = out_id_reg;
  assign rsp_last   = out_last_reg;
  assign lock_abort = lock_abort_reg;

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prefix_adder_arbiter
//
// Directed and random stimulus for prefix_adder_arbiter with LOCK_TIMEOUT=4.
// Every accepted request pushes its expected response (computed by a small
// carry-chain model) onto a queue. Each consumed response is popped and
// compared. Directed steps also check grants, lock behaviour, backpressure,
// timeout abort and asynchronous reset against constants.
// Optional feature macro: PPA_ARB_OVF_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_prefix_adder_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_cin, r0_first, r0_last;
  logic        r1_valid, r1_ready, r1_cin, r1_first, r1_last;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id, rsp_last;
  logic [15:0] rsp_sum;
  logic        lock_abort;
  logic        obs_ovf;

  int total;
  int bad;
  logic [19:0] q[$];          // {ovf, id, last, cout, sum}
  logic        tb_carry [2];
  logic        acc0, acc1;

  prefix_adder_arbiter #(.LOCK_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_a       (r0_a),
    .r0_b       (r0_b),
    .r0_cin     (r0_cin),
    .r0_first   (r0_first),
    .r0_last    (r0_last),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_a       (r1_a),
    .r1_b       (r1_b),
    .r1_cin     (r1_cin),
    .r1_first   (r1_first),
    .r1_last    (r1_last),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .rsp_last   (rsp_last),
`ifdef PPA_ARB_OVF_EN
    .rsp_ovf    (obs_ovf),
`endif
    .lock_abort (lock_abort)
  );

`ifndef PPA_ARB_OVF_EN
  assign obs_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic first, input logic last);
    if (n == 0) begin
      r0_valid = v; r0_a = a; r0_b = b; r0_cin = cin; r0_first = first; r0_last = last;
    end else begin
      r1_valid = v; r1_a = a; r1_b = b; r1_cin = cin; r1_first = first; r1_last = last;
    end
  endtask

  task automatic push(input int id, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic first, input logic last);
    logic        c;
    logic [16:0] s;
    logic        ov;
    c  = first ? cin : tb_carry[id];
    s  = {1'b0, a} + {1'b0, b} + {16'b0, c};
`ifdef PPA_ARB_OVF_EN
    ov = (a[15] == b[15]) && (s[15] != a[15]);
`else
    ov = 1'b0;
`endif
    q.push_back({ov, 1'(id), last, s});
    tb_carry[id] = last ? 1'b0 : s[16];
    $display("req id=%0d a=%h b=%h cin=%0d first=%0d last=%0d -> exp cout=%0d sum=%h",
             id, a, b, c, first, last, s[16], s[15:0]);
  endtask

  // One clock: sample handshakes on the falling edge, then step past the
  // rising edge so the caller can drive new inputs.
  task automatic tick();
    logic [19:0] e;
    @(negedge clk);
    acc0 = r0_valid && r0_ready;
    acc1 = r1_valid && r1_ready;
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL rsp_unexpected observed id=%0d sum=%h expected=no response", rsp_id, rsp_sum);
        end
      end else begin
        e = q.pop_front();
        chk("rsp", 32'({obs_ovf, rsp_id, rsp_last, rsp_cout, rsp_sum}), 32'(e));
      end
    end
    if (acc0) push(0, r0_a, r0_b, r0_cin, r0_first, r0_last);
    if (acc1) push(1, r1_a, r1_b, r1_cin, r1_first, r1_last);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_cnt;
    int left [2];
    int len [2];
    logic pend [2];
    logic [15:0] wa [2];
    logic [15:0] wb [2];
    logic wc [2];
    logic wf [2];
    logic wl [2];

    total = 0; bad = 0;
    tb_carry[0] = 1'b0; tb_carry[1] = 1'b0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({rsp_valid, rsp_cout, rsp_id, rsp_last, lock_abort, r0_ready, r1_ready}), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: alternating grants starting at requester 0, no bubbles
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, 16'($urandom), 16'($urandom), 1'($urandom), 1, 1);
      set_req(1, 1, 16'($urandom), 16'($urandom), 1'($urandom), 1, 1);
      #1;
      chk("cont_gnt", 32'({r1_ready, r0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("cont_out", 32'({rsp_valid, rsp_id}), (k % 2 == 0) ? 32'd2 : 32'd3);
    end

    // Single op
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);
    set_req(0, 1, 16'h1234, 16'h5678, 0, 1, 1);
    #1;
    chk("single_rdy", 32'(r0_ready), 32'd1);
    tick();
    chk("single_out", 32'({rsp_valid, rsp_cout, rsp_id, rsp_last, rsp_sum}),
        32'({1'b1, 1'b0, 1'b0, 1'b1, 16'h68AC}));

    // Chain on requester 1 while requester 0 waits
    set_req(1, 1, 16'hFFFF, 16'h0001, 0, 1, 0);
    set_req(0, 1, 16'h0102, 16'h0304, 0, 1, 1);
    #1;
    chk("chain_gnt0", 32'({r1_ready, r0_ready}), 32'd2);
    tick();
    chk("chain_w0", 32'({rsp_cout, rsp_id, rsp_last, rsp_sum}), 32'({1'b1, 1'b1, 1'b0, 16'h0000}));
    set_req(1, 1, 16'h0000, 16'h0000, 0, 0, 1);
    #1;
    chk("chain_gnt1", 32'({r1_ready, r0_ready}), 32'd2);
    tick();
    chk("chain_w1", 32'({rsp_cout, rsp_id, rsp_last, rsp_sum}), 32'({1'b0, 1'b1, 1'b1, 16'h0001}));
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);
    #1;
    chk("chain_r0", 32'({r1_ready, r0_ready}), 32'd1);
    tick();

    // Backpressure: three stalled cycles, then accept in the release cycle
    set_req(0, 1, 16'hA5A5, 16'h5A5A, 1, 1, 1);
    set_req(1, 1, 16'h8000, 16'h8000, 0, 1, 1);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 32'({r1_ready, r0_ready}), 32'd0);
      chk("bp_hold", 32'({obs_ovf, rsp_id, rsp_last, rsp_cout, rsp_sum}), 32'(q[0]));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume", 32'({r1_ready, r0_ready}), 32'd2);
    tick();
    chk("bp_valid", 32'({rsp_valid, rsp_id}), 32'd3);
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);
    tick();
    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    repeat (2) tick();

    // Lock timeout: r0 opens a chain then goes idle while r1 waits
    set_req(0, 1, 16'hFFFF, 16'h0001, 0, 1, 0);
    tick();
    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    set_req(1, 1, 16'h0011, 16'h0022, 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("to_wait", 32'({lock_abort, r1_ready}), 32'd0);
      tick();
    end
    #1;
    chk("to_abort", 32'({lock_abort, r1_ready}), 32'd3);
    tb_carry[0] = 1'b0;
    tick();
    chk("to_pulse", 32'(lock_abort), 32'd0);
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);
    set_req(0, 1, 16'h0000, 16'h0000, 1, 0, 1);
    #1;
    chk("to_rdy", 32'(r0_ready), 32'd1);
    tick();
    chk("to_cleared", 32'({rsp_cout, rsp_sum}), 32'd0);
    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    tick();

    // Asynchronous reset in the middle of a locked transaction
    set_req(0, 1, 16'h4444, 16'h1111, 0, 1, 0);
    tick();
    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'({rsp_valid, rsp_cout, rsp_id, rsp_last, lock_abort, rsp_sum}), 32'd0);
    q.delete();
    tb_carry[0] = 1'b0; tb_carry[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1, 1, 16'h0003, 16'h0004, 1, 1, 1);
    #1;
    chk("arst_rdy", 32'({r1_ready, r0_ready}), 32'd2);
    tick();
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);
    tick();

`ifdef PPA_ARB_OVF_EN
    set_req(0, 1, 16'h7FFF, 16'h0001, 0, 1, 1);
    tick();
    chk("ovf", 32'({obs_ovf, rsp_sum}), 32'({1'b1, 16'h8000}));
    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    tick();
`endif

    // Random mixed single/chained traffic with random backpressure
    acc_cnt = 0;
    for (int n = 0; n < 2; n++) begin
      left[n] = 0; len[n] = 0; pend[n] = 1'b0;
      wa[n] = '0; wb[n] = '0; wc[n] = 1'b0; wf[n] = 1'b0; wl[n] = 1'b0;
    end
    for (int cyc = 0; cyc < 4000 && (acc_cnt < 200 || left[0] != 0 || left[1] != 0); cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && (left[n] != 0 || (acc_cnt < 200 && $urandom_range(0, 3) != 0))) begin
          if (left[n] == 0) begin
            len[n]  = $urandom_range(1, 3);
            left[n] = len[n];
          end
          pend[n] = 1'b1;
          wa[n] = 16'($urandom);
          wb[n] = 16'($urandom);
          wc[n] = 1'($urandom);
          wf[n] = (left[n] == len[n]);
          wl[n] = (left[n] == 1);
        end
        set_req(n, pend[n], wa[n], wb[n], wc[n], wf[n], wl[n]);
      end
      rsp_ready = ($urandom_range(0, 4) != 0);
      tick();
      if (acc0) begin pend[0] = 1'b0; left[0]--; acc_cnt++; end
      if (acc1) begin pend[1] = 1'b0; left[1]--; acc_cnt++; end
    end
    chk("rand_done", 32'(acc_cnt >= 200 && left[0] == 0 && left[1] == 0), 32'd1);

    set_req(0, 0, 16'h0, 16'h0, 0, 0, 0);
    set_req(1, 0, 16'h0, 16'h0, 0, 0, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
